// File: rtl/data_memory_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request waits LATENCY cycles before the array is accessed; one request in flight at a time.
module data_memory_responder #(
  parameter int DATA_W  = 20,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, nextState;
  logic              latWrite;
  logic [DATA_W-1:0] latAddr;
  logic [DATA_W-1:0] latWdata;
  logic [3:0]        waitCnt;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              accept;
  logic              accessNow;
  logic              inRange;
  logic [ADDR_W-1:0] idx;

  assign accept    = (state == IDLE) && req_valid;
  assign accessNow = (state == WAIT) && (waitCnt == 4'd0);
  assign inRange   = (latAddr[DATA_W-1:ADDR_W] == '0);
  assign idx       = latAddr[ADDR_W-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Every accepted request spends at least one cycle in WAIT, so the array
  // access lands LATENCY+1 edges after the accept edge.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req_valid) nextState = WAIT;
      WAIT:    if (waitCnt == 4'd0) nextState = RESP;
      RESP:    if (resp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      latWrite   <= 1'b0;
      latAddr    <= '0;
      latWdata   <= '0;
      waitCnt    <= 4'd0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        latWrite <= req_write;
        latAddr  <= req_addr;
        latWdata <= req_wdata;
        waitCnt  <= 4'(LATENCY);
      end else if ((state == WAIT) && (waitCnt != 4'd0)) begin
        waitCnt <= waitCnt - 4'd1;
      end
      if (accessNow) begin
        resp_error <= !inRange;
        resp_rdata <= (inRange && !latWrite) ? mem[idx] : '0;
      end else if ((state == RESP) && resp_ready) begin
        resp_error <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end

  // Storage is deliberately not reset; a reset during WAIT holds the FSM in
  // IDLE over the edge, so accessNow stays low and the store is dropped.
  always_ff @(posedge clock) begin
    if (accessNow && latWrite && inRange) mem[idx] <= latWdata;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: LATENCY=2 responder for protocol/data checks, LATENCY=0 responder for pipelining.
module tb_data_memory_responder;

  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          reqValid, reqWrite, reqReady, respValid, respReady, respError;
  logic [DW-1:0] reqAddr, reqWdata, respRdata;
  logic          bReqValid, bReqWrite, bReqReady, bRespValid, bRespReady, bRespError;
  logic [DW-1:0] bReqAddr, bReqWdata, bRespRdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_responder #(.DATA_W(DW), .ADDR_W(8), .LATENCY(2)) dut (
    .clock(clk), .reset(rst),
    .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata),
    .req_ready(reqReady), .resp_valid(respValid), .resp_ready(respReady),
    .resp_rdata(respRdata), .resp_error(respError)
  );

  data_memory_responder #(.DATA_W(DW), .ADDR_W(8), .LATENCY(0)) dut0 (
    .clock(clk), .reset(rst),
    .req_valid(bReqValid), .req_write(bReqWrite), .req_addr(bReqAddr), .req_wdata(bReqWdata),
    .req_ready(bReqReady), .resp_valid(bRespValid), .resp_ready(bRespReady),
    .resp_rdata(bRespRdata), .resp_error(bRespError)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and clock the accept edge (caller ensures IDLE).
  task automatic issue(input logic w, input logic [DW-1:0] a, input logic [DW-1:0] d);
    reqValid = 1'b1; reqWrite = w; reqAddr = a; reqWdata = d;
    tick();
    reqValid = 1'b0;
  endtask

  // Edges from the accept edge until resp_valid is seen (bounded).
  task automatic waitResp(output int n);
    n = 0;
    while (!respValid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    respReady = 1'b1;
    tick();
    respReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", reqReady); end
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", respValid); end
    total++; if (respRdata !== 20'h0) begin bad++; $display("FAIL reset_rdata got=%h want=00000", respRdata); end
    total++; if (respError !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", respError); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    int n;
    issue(1'b1, 20'h00005, 20'h0ABCD);
    waitResp(n);
    total++; if (n !== 3) begin bad++; $display("FAIL store_latency got=%0d want=3", n); end
    total++; if (respRdata !== 20'h0) begin bad++; $display("FAIL store_rdata got=%h want=00000", respRdata); end
    total++; if (respError !== 1'b0) begin bad++; $display("FAIL store_error got=%b want=0", respError); end
    consume();
    total++; if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      bad++; $display("FAIL store_handshake got rv=%b rr=%b want rv=0 rr=1", respValid, reqReady);
    end
    issue(1'b0, 20'h00005, 20'h0);
    waitResp(n);
    total++; if (n !== 3) begin bad++; $display("FAIL load_latency got=%0d want=3", n); end
    total++; if (respRdata !== 20'h0ABCD) begin bad++; $display("FAIL load_rdata got=%h want=0abcd", respRdata); end
    total++; if (respError !== 1'b0) begin bad++; $display("FAIL load_error got=%b want=0", respError); end
    consume();
  endtask

  task automatic test_out_of_range();
    int n;
    issue(1'b1, 20'h00105, 20'h12345);
    waitResp(n);
    total++; if (respError !== 1'b1) begin bad++; $display("FAIL oor_error got=%b want=1", respError); end
    total++; if (respRdata !== 20'h0) begin bad++; $display("FAIL oor_rdata got=%h want=00000", respRdata); end
    consume();
    issue(1'b0, 20'h00005, 20'h0);
    waitResp(n);
    total++; if (respRdata !== 20'h0ABCD) begin bad++; $display("FAIL oor_alias_rdata got=%h want=0abcd", respRdata); end
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    issue(1'b0, 20'h00005, 20'h0);
    waitResp(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (respValid !== 1'b1 || respRdata !== 20'h0ABCD || respError !== 1'b0 || reqReady !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] got rv=%b d=%h e=%b rr=%b want rv=1 d=0abcd e=0 rr=0",
                        i, respValid, respRdata, respError, reqReady);
      end
    end
    consume();
    total++; if (respValid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b want=0", respValid); end
  endtask

  task automatic test_ignored();
    int n;
    issue(1'b1, 20'h00007, 20'h00042);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 20'h00008; reqWdata = 20'h00099;
    waitResp(n);
    total++; if (n !== 3) begin bad++; $display("FAIL ign_latency got=%0d want=3", n); end
    consume();
    total++; if (reqReady !== 1'b1) begin bad++; $display("FAIL ign_idle got=%b want=1", reqReady); end
    tick();
    reqValid = 1'b0;
    total++; if (reqReady !== 1'b0) begin bad++; $display("FAIL ign_accept got=%b want=0", reqReady); end
    waitResp(n);
    total++; if (n !== 3) begin bad++; $display("FAIL ign_second_latency got=%0d want=3", n); end
    consume();
    issue(1'b0, 20'h00007, 20'h0);
    waitResp(n);
    total++; if (respRdata !== 20'h00042) begin bad++; $display("FAIL ign_addr7 got=%h want=00042", respRdata); end
    consume();
    issue(1'b0, 20'h00008, 20'h0);
    waitResp(n);
    total++; if (respRdata !== 20'h00099) begin bad++; $display("FAIL ign_addr8 got=%h want=00099", respRdata); end
    consume();
  endtask

  task automatic test_reset_mid_store();
    int n;
    issue(1'b1, 20'h00009, 20'h00111);
    waitResp(n);
    consume();
    issue(1'b1, 20'h00009, 20'h00077);
    tick();
    rst = 1'b1;
    #2;
    total++; if (reqReady !== 1'b1 || respValid !== 1'b0 || respRdata !== 20'h0 || respError !== 1'b0) begin
      bad++; $display("FAIL rst_wait got rr=%b rv=%b d=%h e=%b want rr=1 rv=0 d=00000 e=0",
                      reqReady, respValid, respRdata, respError);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(1'b0, 20'h00009, 20'h0);
    waitResp(n);
    total++; if (respRdata !== 20'h00111) begin bad++; $display("FAIL rst_abort_rdata got=%h want=00111", respRdata); end
    consume();
  endtask

  // LATENCY=0 with resp_ready tied high: accepts at edges 0,3,6,9; stores first, then loads.
  task automatic test_back_to_back();
    logic rr;
    bReqValid = 1'b1; bReqAddr = 20'h00003; bReqWdata = 20'h00033;
    for (int k = 0; k < 12; k++) begin
      bReqWrite = (k < 6);
      rr = bReqReady;
      tick();
      total++; if (rr !== (k % 3 == 0)) begin
        bad++; $display("FAIL b2b_accept[%0d] got=%b want=%b", k, rr, (k % 3 == 0));
      end
      total++; if (bRespValid !== (k % 3 == 1)) begin
        bad++; $display("FAIL b2b_resp_valid[%0d] got=%b want=%b", k, bRespValid, (k % 3 == 1));
      end
      if (k == 1 || k == 4) begin
        total++; if (bRespRdata !== 20'h0) begin bad++; $display("FAIL b2b_store_rdata[%0d] got=%h want=00000", k, bRespRdata); end
      end
      if (k == 7 || k == 10) begin
        total++; if (bRespRdata !== 20'h00033) begin bad++; $display("FAIL b2b_load_rdata[%0d] got=%h want=00033", k, bRespRdata); end
      end
    end
    bReqValid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0; respReady = 1'b0;
    bReqValid = 1'b0; bReqWrite = 1'b0; bReqAddr = '0; bReqWdata = '0; bRespReady = 1'b1;
    test_reset();
    test_store_load();
    test_out_of_range();
    test_backpressure();
    test_ignored();
    test_reset_mid_store();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
